// File: rtl/axi3_hp_wr_responder.sv
// ---------------------------------------------------------------------------
// axi3_hp_wr_responder
//
// AXI3 write-channel slave that terminates the PS HP0 write port in
// stand-alone benches and board test images. DMA bursts land in a
// word-addressed BRAM window. Each burst gets one B-channel response. A
// registered readback port and two counters let checkers inspect the
// captured data without the Zynq BFM.
//
// Ports:
//   clk_i, resetn_i        clock, asynchronous active-low reset
//   s_aw*                  AXI3 write address channel (slave side)
//   s_w*                   AXI3 write data channel (slave side)
//   s_b*                   AXI3 write response channel (slave side)
//   rd_addr_i / rd_data_o  readback word index / mem word, 1-cycle latency
//   beat_count_o           beats actually written to memory (wraps)
//   burst_count_o          completed B handshakes (wraps)
//   err_o                  sticky flag, set by any non-OKAY response
//
// Build option:
//   AXI_BACKPRESSURE_EN    a free-running 16-bit LFSR randomly withholds
//                          AWREADY (bit 0) and WREADY (bit 1) to exercise
//                          master stall handling.
// ---------------------------------------------------------------------------
module axi3_hp_wr_responder #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          ID_WIDTH   = 6,
    parameter int          MEM_DEPTH  = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         resetn_i,
    input  logic [ID_WIDTH-1:0]          s_awid_i,
    input  logic [ADDR_WIDTH-1:0]        s_awaddr_i,
    input  logic [3:0]                   s_awlen_i,
    input  logic [2:0]                   s_awsize_i,
    input  logic [1:0]                   s_awburst_i,
    input  logic                         s_awvalid_i,
    output logic                         s_awready_o,
    input  logic [ID_WIDTH-1:0]          s_wid_i,
    input  logic [DATA_WIDTH-1:0]        s_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]      s_wstrb_i,
    input  logic                         s_wlast_i,
    input  logic                         s_wvalid_i,
    output logic                         s_wready_o,
    output logic [ID_WIDTH-1:0]          s_bid_o,
    output logic [1:0]                   s_bresp_o,
    output logic                         s_bvalid_o,
    input  logic                         s_bready_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0]        rd_data_o,
    output logic [31:0]                  beat_count_o,
    output logic [31:0]                  burst_count_o,
    output logic                         err_o
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(4 * MEM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic                    active_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [3:0]              len_q;
    logic [1:0]              burst_q;
    logic                    no_write_q;
    logic [1:0]              resp_q;
    logic [3:0]              beat_q;
    logic [31:0]             beat_count_q;
    logic [31:0]             burst_count_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    bp_aw, bp_w;
    logic                    aw_hs, w_hs, b_hs;
    logic [ADDR_WIDTH-1:0]   offset;
    logic                    in_window, final_beat, burst_done, mem_we;
    logic [IDX_W-1:0]        word_idx;
    logic [1:0]              beat_resp;

`ifdef AXI_BACKPRESSURE_EN
    // Free-running Fibonacci LFSR (x^16+x^14+x^13+x^11); its low bits
    // randomly withhold the readies.
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign bp_aw = lfsr_q[0];
    assign bp_w  = lfsr_q[1];
`else
    assign bp_aw = 1'b1;
    assign bp_w  = 1'b1;
`endif

    assign aw_hs = s_awvalid_i & s_awready_o;
    assign w_hs  = s_wvalid_i & s_wready_o;
    assign b_hs  = s_bvalid_o & s_bready_i;

    // An address below BASE wraps to a huge offset, so one unsigned compare
    // covers both window edges.
    assign offset     = addr_q - BASE;
    assign in_window  = (offset < WIN_BYTES);
    assign word_idx   = offset[IDX_W+1:2];
    assign final_beat = (beat_q == len_q);
    assign burst_done = w_hs & (final_beat | s_wlast_i);
    assign mem_we     = w_hs & in_window & ~no_write_q;

    // Per-beat response. An out-of-window beat is DECERR, and that outranks
    // every SLVERR cause.
    always_comb begin
        beat_resp = 2'b00;
        if (!in_window) begin
            beat_resp = 2'b11;
        end else if (no_write_q || (s_wlast_i != final_beat) || (s_wid_i != id_q)) begin
            beat_resp = 2'b10;
        end
    end

    // State register. active_q keeps AWREADY low while in reset and rises on
    // the first edge after release.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
        end
    end

    // Next-state logic. Only one burst is outstanding at a time.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (aw_hs)      state_d = ST_DATA;
            ST_DATA: if (burst_done) state_d = ST_RESP;
            ST_RESP: if (b_hs)       state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Outputs. BID and BRESP show the latched values only while the
    // response is being offered.
    always_comb begin
        s_awready_o = active_q & (state_q == ST_IDLE) & bp_aw;
        s_wready_o  = (state_q == ST_DATA) & bp_w;
        s_bvalid_o  = (state_q == ST_RESP);
        s_bid_o     = (state_q == ST_RESP) ? id_q : '0;
        s_bresp_o   = (state_q == ST_RESP) ? resp_q : 2'b00;
    end

    // Burst context and counters. A burst that can never be written (wrong
    // size, WRAP or unaligned start) starts with SLVERR already
    // accumulated. A later DECERR beat can still raise the response.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            id_q          <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            burst_q       <= '0;
            no_write_q    <= 1'b0;
            resp_q        <= 2'b00;
            beat_q        <= '0;
            beat_count_q  <= '0;
            burst_count_q <= '0;
            err_q         <= 1'b0;
        end else begin
            if (aw_hs) begin
                id_q       <= s_awid_i;
                addr_q     <= s_awaddr_i;
                len_q      <= s_awlen_i;
                burst_q    <= s_awburst_i;
                no_write_q <= (s_awsize_i != 3'b010) || (s_awburst_i == 2'b10) ||
                              (s_awaddr_i[1:0] != 2'b00);
                resp_q     <= ((s_awsize_i != 3'b010) || (s_awburst_i == 2'b10) ||
                               (s_awaddr_i[1:0] != 2'b00)) ? 2'b10 : 2'b00;
                beat_q     <= '0;
            end
            if (w_hs) begin
                beat_q <= beat_q + 4'd1;
                if (burst_q != 2'b00) begin
                    addr_q <= addr_q + ADDR_WIDTH'(4);
                end
                if (beat_resp > resp_q) begin
                    resp_q <= beat_resp;
                end
            end
            if (mem_we) begin
                beat_count_q <= beat_count_q + 32'd1;
            end
            if (b_hs) begin
                burst_count_q <= burst_count_q + 32'd1;
                err_q         <= err_q | (resp_q != 2'b00);
            end
        end
    end

    // BRAM write port with byte enables. The contents are not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_wstrb_i[b]) begin
                    mem[word_idx][8*b +: 8] <= s_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Readback port. A read of the word written in the same cycle returns
    // the old data.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o     = rd_data_q;
    assign beat_count_o  = beat_count_q;
    assign burst_count_o = burst_count_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_axi3_hp_wr_responder.sv
// ---------------------------------------------------------------------------
// tb_axi3_hp_wr_responder
//
// Self-checking bench for axi3_hp_wr_responder using default parameters.
// A behavioural model computes the expected memory image, the counters and
// the B response of each burst. Expected responses are queued when a burst
// is driven and are popped and compared when the DUT offers its response.
// ---------------------------------------------------------------------------
module tb_axi3_hp_wr_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  s_awid;
    logic [31:0] s_awaddr;
    logic [3:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic        s_awvalid;
    logic        s_awready;
    logic [5:0]  s_wid;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast;
    logic        s_wvalid;
    logic        s_wready;
    logic [5:0]  s_bid;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] beat_count;
    logic [31:0] burst_count;
    logic        err;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
    } b_exp_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_mem [1024];
    int          exp_beats  = 0;
    int          exp_bursts = 0;
    logic        exp_err    = 1'b0;
    b_exp_t      exp_q [$];
    logic [31:0] burst_data [16];

    always #5 clk = ~clk;

    axi3_hp_wr_responder dut (
        .clk_i         (clk),
        .resetn_i      (resetn),
        .s_awid_i      (s_awid),
        .s_awaddr_i    (s_awaddr),
        .s_awlen_i     (s_awlen),
        .s_awsize_i    (s_awsize),
        .s_awburst_i   (s_awburst),
        .s_awvalid_i   (s_awvalid),
        .s_awready_o   (s_awready),
        .s_wid_i       (s_wid),
        .s_wdata_i     (s_wdata),
        .s_wstrb_i     (s_wstrb),
        .s_wlast_i     (s_wlast),
        .s_wvalid_i    (s_wvalid),
        .s_wready_o    (s_wready),
        .s_bid_o       (s_bid),
        .s_bresp_o     (s_bresp),
        .s_bvalid_o    (s_bvalid),
        .s_bready_i    (s_bready),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .beat_count_o  (beat_count),
        .burst_count_o (burst_count),
        .err_o         (err)
    );

    // Global watchdog so that a stuck handshake still ends the run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic aw_send(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(negedge clk);
        s_awid    = id;
        s_awaddr  = addr;
        s_awlen   = len;
        s_awsize  = size;
        s_awburst = burst;
        s_awvalid = 1'b1;
        while (!s_awready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_awready) begin
            checks++;
            failures++;
            $display("[TB] FAIL aw_timeout awready=%b required=1", s_awready);
        end
        @(posedge clk);
        #1 s_awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [5:0] id, input logic [31:0] data, input logic [3:0] strb,
                          input logic last);
        int n = 0;
        @(negedge clk);
        s_wid    = id;
        s_wdata  = data;
        s_wstrb  = strb;
        s_wlast  = last;
        s_wvalid = 1'b1;
        while (!s_wready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_wready) begin
            checks++;
            failures++;
            $display("[TB] FAIL w_timeout wready=%b required=1", s_wready);
        end
        @(posedge clk);
        #1 s_wvalid = 1'b0;
    endtask

    // Waits for BVALID, pops the expected response and compares it. BREADY
    // is then held low for 'hold' cycles, during which the response must
    // stay stable. One handshake follows.
    task automatic drive_b(input int hold);
        int     n = 0;
        b_exp_t e;
        @(negedge clk);
        while (!s_bvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_bvalid) begin
            checks++;
            failures++;
            $display("[TB] FAIL b_timeout bvalid=%b required=1", s_bvalid);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL b_unexpected bvalid=1 required no response");
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (s_bid !== e.id) begin
            failures++;
            $display("[TB] FAIL bid got=%h required=%h", s_bid, e.id);
        end
        checks++;
        if (s_bresp !== e.resp) begin
            failures++;
            $display("[TB] FAIL bresp got=%b required=%b", s_bresp, e.resp);
        end
        checks++;
        if (s_awready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL awready_in_resp got=%b required=0", s_awready);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if ({s_bvalid, s_bid, s_bresp} !== {1'b1, e.id, e.resp}) begin
                failures++;
                $display("[TB] FAIL b_stable cycle=%0d got=%b/%h/%b required=1/%h/%b",
                         h, s_bvalid, s_bid, s_bresp, e.id, e.resp);
            end
        end
        s_bready = 1'b1;
        @(posedge clk);
        #1 s_bready = 1'b0;
        exp_bursts++;
        if (e.resp != 2'b00) exp_err = 1'b1;
        @(negedge clk);
        checks++;
        if (s_bvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b_single got bvalid=%b required=0", s_bvalid);
        end
    endtask

    // Models one burst, queues its expected response and drives it.
    // last_at is the beat index that carries WLAST (>len means never).
    task automatic run_burst(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                             input int last_at, input logic [5:0] wid, input int hold);
        logic        no_wr;
        logic [1:0]  resp;
        logic [1:0]  br;
        logic [31:0] a;
        b_exp_t      e;
        int          l = int'(len);
        int          nbeats;
        no_wr  = (size != 3'b010) || (burst == 2'b10) || (addr[1:0] != 2'b00);
        resp   = no_wr ? 2'b10 : 2'b00;
        a      = addr;
        nbeats = (last_at < l) ? last_at + 1 : l + 1;
        for (int k = 0; k < nbeats; k++) begin
            br = 2'b00;
            if (a >= 32'd4096) begin
                br = 2'b11;
            end else begin
                if (no_wr) br = 2'b10;
                if (k == last_at && k != l) br = 2'b10;
                if (k == l && last_at != l) br = 2'b10;
                if (wid != id) br = 2'b10;
                if (!no_wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (strb[b]) exp_mem[int'(a[11:2])][8*b +: 8] = burst_data[k][8*b +: 8];
                    end
                    exp_beats++;
                end
            end
            if (br > resp) resp = br;
            if (burst != 2'b00) a = a + 32'd4;
        end
        e.id   = id;
        e.resp = resp;
        exp_q.push_back(e);
        aw_send(id, addr, len, size, burst);
        for (int k = 0; k < nbeats; k++) begin
            w_send(wid, burst_data[k], strb, (k == last_at));
        end
        drive_b(hold);
    endtask

    task automatic read_word(input int idx, output logic [31:0] v);
        @(negedge clk);
        rd_addr = 10'(idx);
        @(posedge clk);
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'b010; s_awburst = 2'b01;
        s_wid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0;
        rd_addr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_awready, s_wready, s_bvalid, s_bresp, s_bid} !== 11'b0) begin
            failures++;
            $display("[TB] FAIL reset_handshake got=%b required=0", {s_awready, s_wready, s_bvalid, s_bresp, s_bid});
        end
        checks++;
        if ({rd_data, beat_count, burst_count, err} !== 97'b0) begin
            failures++;
            $display("[TB] FAIL reset_regs got rd=%h beats=%0d bursts=%0d err=%b required 0",
                     rd_data, beat_count, burst_count, err);
        end
        resetn = 1'b1;
    endtask

    task automatic test_incr();
        logic [31:0] v;
        for (int k = 0; k < 16; k++) burst_data[k] = 32'(k);
        run_burst(6'h05, 32'h0, 4'd15, 3'b010, 2'b01, 4'hF, 15, 6'h05, 0);
        for (int k = 0; k < 16; k++) begin
            read_word(k, v);
            checks++;
            if (v !== 32'(k)) begin
                failures++;
                $display("[TB] FAIL incr_mem[%0d] got=%h required=%h", k, v, 32'(k));
            end
        end
        checks++;
        if (beat_count !== 32'd16 || burst_count !== 32'd1 || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL incr_counters got=%0d/%0d/%b required=16/1/0", beat_count, burst_count, err);
        end
    endtask

    task automatic test_fixed();
        logic [31:0] v;
        burst_data[0] = 32'hAAAA_AAAA;
        burst_data[1] = 32'hBBBB_BBBB;
        burst_data[2] = 32'hCCCC_CCCC;
        burst_data[3] = 32'hDDDD_DDDD;
        run_burst(6'h11, 32'h40, 4'd3, 3'b010, 2'b00, 4'hF, 3, 6'h11, 0);
        read_word(16, v);
        checks++;
        if (v !== 32'hDDDD_DDDD) begin
            failures++;
            $display("[TB] FAIL fixed_mem16 got=%h required=DDDDDDDD", v);
        end
        read_word(17, v);
        checks++;
        if (v !== exp_mem[17]) begin
            failures++;
            $display("[TB] FAIL fixed_mem17 got=%h required=%h", v, exp_mem[17]);
        end
        burst_data[0] = 32'h1234_5678;
        run_burst(6'h12, 32'h40, 4'd0, 3'b010, 2'b01, 4'b0011, 0, 6'h12, 0);
        read_word(16, v);
        checks++;
        if (v !== 32'hDDDD_5678) begin
            failures++;
            $display("[TB] FAIL strb_merge got=%h required=DDDD5678", v);
        end
        checks++;
        if (beat_count !== 32'(exp_beats)) begin
            failures++;
            $display("[TB] FAIL fixed_beats got=%0d required=%0d", beat_count, exp_beats);
        end
    endtask

    task automatic test_decerr();
        logic [31:0] v;
        for (int k = 0; k < 16; k++) burst_data[k] = 32'hD0D0_0000 + 32'(k);
        run_burst(6'h21, 32'hFF8, 4'd3, 3'b010, 2'b01, 4'hF, 3, 6'h21, 0);
        for (int k = 1022; k < 1024; k++) begin
            read_word(k, v);
            checks++;
            if (v !== exp_mem[k]) begin
                failures++;
                $display("[TB] FAIL decerr_mem[%0d] got=%h required=%h", k, v, exp_mem[k]);
            end
        end
        checks++;
        if (beat_count !== 32'(exp_beats) || err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL decerr_counters got=%0d/%b required=%0d/1", beat_count, err, exp_beats);
        end
    endtask

    task automatic test_early_last();
        logic [31:0] v;
        for (int k = 0; k < 16; k++) burst_data[k] = 32'hE000_0000 + 32'(k);
        run_burst(6'h2A, 32'h100, 4'd7, 3'b010, 2'b01, 4'hF, 2, 6'h2A, 5);
        for (int k = 64; k < 67; k++) begin
            read_word(k, v);
            checks++;
            if (v !== exp_mem[k]) begin
                failures++;
                $display("[TB] FAIL early_mem[%0d] got=%h required=%h", k, v, exp_mem[k]);
            end
        end
        checks++;
        if (beat_count !== 32'(exp_beats) || burst_count !== 32'(exp_bursts)) begin
            failures++;
            $display("[TB] FAIL early_counters got=%0d/%0d required=%0d/%0d",
                     beat_count, burst_count, exp_beats, exp_bursts);
        end
    endtask

    task automatic test_slverr_nowrite();
        logic [31:0] v;
        for (int k = 0; k < 16; k++) burst_data[k] = 32'hBAD0_0000 + 32'(k);
        run_burst(6'h31, 32'h0, 4'd1, 3'b011, 2'b01, 4'hF, 1, 6'h31, 0);
        run_burst(6'h32, 32'h0, 4'd1, 3'b010, 2'b10, 4'hF, 1, 6'h32, 0);
        run_burst(6'h33, 32'h2, 4'd1, 3'b010, 2'b01, 4'hF, 1, 6'h33, 0);
        for (int k = 0; k < 2; k++) begin
            read_word(k, v);
            checks++;
            if (v !== exp_mem[k]) begin
                failures++;
                $display("[TB] FAIL nowrite_mem[%0d] got=%h required=%h", k, v, exp_mem[k]);
            end
        end
        checks++;
        if (beat_count !== 32'(exp_beats)) begin
            failures++;
            $display("[TB] FAIL nowrite_beats got=%0d required=%0d", beat_count, exp_beats);
        end
    endtask

    task automatic test_wid_mismatch();
        logic [31:0] v;
        for (int k = 0; k < 16; k++) burst_data[k] = 32'h1D00_0000 + 32'(k);
        run_burst(6'h07, 32'h200, 4'd3, 3'b010, 2'b01, 4'hF, 3, 6'h08, 0);
        for (int k = 128; k < 132; k++) begin
            read_word(k, v);
            checks++;
            if (v !== exp_mem[k]) begin
                failures++;
                $display("[TB] FAIL wid_mem[%0d] got=%h required=%h", k, v, exp_mem[k]);
            end
        end
    endtask

    task automatic test_reset_midburst();
        logic [31:0] v;
        aw_send(6'h33, 32'h300, 4'd15, 3'b010, 2'b01);
        for (int k = 0; k < 5; k++) begin
            w_send(6'h33, 32'h3000_0000 + 32'(k), 4'hF, 1'b0);
            exp_mem[192 + k] = 32'h3000_0000 + 32'(k);
        end
        @(negedge clk);
        s_wid    = 6'h33;
        s_wdata  = 32'h3000_0005;
        s_wstrb  = 4'hF;
        s_wlast  = 1'b0;
        s_wvalid = 1'b1;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({s_awready, s_wready, s_bvalid, s_bresp, s_bid} !== 11'b0) begin
            failures++;
            $display("[TB] FAIL midrst_handshake got=%b required=0", {s_awready, s_wready, s_bvalid, s_bresp, s_bid});
        end
        checks++;
        if ({rd_data, beat_count, burst_count, err} !== 97'b0) begin
            failures++;
            $display("[TB] FAIL midrst_regs got rd=%h beats=%0d bursts=%0d err=%b required 0",
                     rd_data, beat_count, burst_count, err);
        end
        @(negedge clk);
        s_wvalid   = 1'b0;
        resetn     = 1'b1;
        exp_beats  = 0;
        exp_bursts = 0;
        exp_err    = 1'b0;
        for (int k = 192; k < 197; k++) begin
            read_word(k, v);
            checks++;
            if (v !== exp_mem[k]) begin
                failures++;
                $display("[TB] FAIL midrst_mem[%0d] got=%h required=%h", k, v, exp_mem[k]);
            end
        end
        for (int k = 0; k < 16; k++) burst_data[k] = 32'h4000_0000 + 32'(k);
        run_burst(6'h34, 32'h400, 4'd3, 3'b010, 2'b01, 4'hF, 3, 6'h34, 0);
        checks++;
        if (beat_count !== 32'd4 || burst_count !== 32'd1 || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_after got=%0d/%0d/%b required=4/1/0", beat_count, burst_count, err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn     = 1'b1;
        exp_beats  = 0;
        exp_bursts = 0;
        exp_err    = 1'b0;
        for (int b = 0; b < 64; b++) begin
            for (int k = 0; k < 16; k++) burst_data[k] = 32'hB000_0000 | (32'(b) << 8) | 32'(k);
            run_burst(6'(b), 32'(b * 64), 4'd15, 3'b010, 2'b01, 4'hF, 15, 6'(b), 0);
        end
        checks++;
        if (beat_count !== 32'd1024 || burst_count !== 32'd64 || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_counters got=%0d/%0d/%b required=1024/64/0", beat_count, burst_count, err);
        end
        for (int k = 0; k < 1024; k += 61) begin
            read_word(k, v);
            checks++;
            if (v !== exp_mem[k]) begin
                failures++;
                $display("[TB] FAIL b2b_mem[%0d] got=%h required=%h", k, v, exp_mem[k]);
            end
        end
        read_word(1023, v);
        checks++;
        if (v !== 32'hB000_3F0F) begin
            failures++;
            $display("[TB] FAIL b2b_mem_last got=%h required=B0003F0F", v);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
        test_reset();
        test_incr();
        test_fixed();
        test_decerr();
        test_early_last();
        test_slverr_nowrite();
        test_wid_mismatch();
        test_reset_midburst();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
